camera_coord_gen: RTL and testbench

//  Front end of the video path. Samples the raw camera stream (frame_valid, line_valid, pixel_valid, data).

---
 rtl/camera_coord_gen.sv | 120 ++++++++++++
 tb/tb_camera_coord_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/camera_coord_gen.sv
// Camera front end: qualifies the raw camera stream and emits each accepted pixel
// one cycle later, tagged with its screen coordinate (all-ones sentinel when idle).
module camera_coord_gen #(
    parameter int SCREEN_X_BITWIDTH     = 9,
    parameter int SCREEN_Y_BITWIDTH     = 8,
    parameter int CAMERA_PIXEL_BITWIDTH = 7,
    parameter int SCREEN_WIDTH          = 640,
    parameter int SCREEN_HEIGHT         = 480
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             frame_valid,
    input  logic                             line_valid,
    input  logic                             pixel_valid,
    input  logic [CAMERA_PIXEL_BITWIDTH:0]   pixel_data,
    output logic [SCREEN_X_BITWIDTH:0]       screen_x,
    output logic [SCREEN_Y_BITWIDTH:0]       screen_y,
    output logic [CAMERA_PIXEL_BITWIDTH:0]   pixel_in,
    output logic                             pixel_out_valid,
    output logic                             frame_start,
    output logic                             frame_done,
    output logic                             frame_err
);

    localparam int XW = SCREEN_X_BITWIDTH + 1;
    localparam int YW = SCREEN_Y_BITWIDTH + 1;
    localparam logic [SCREEN_X_BITWIDTH:0] X_LIMIT = XW'(SCREEN_WIDTH);
    localparam logic [SCREEN_Y_BITWIDTH:0] Y_LIMIT = YW'(SCREEN_HEIGHT);

    // The all-ones sentinel must never collide with a real coordinate.
    if (SCREEN_WIDTH < 1 || SCREEN_WIDTH >= (1 << XW)) begin : g_x_check
        $error("SCREEN_WIDTH does not fit below the x sentinel");
    end
    if (SCREEN_HEIGHT < 1 || SCREEN_HEIGHT >= (1 << YW)) begin : g_y_check
        $error("SCREEN_HEIGHT does not fit below the y sentinel");
    end

    typedef enum logic [1:0] {SYNC, WAIT_FV, ACTIVE} state_t;

    state_t                  state, state_n;
    logic [SCREEN_X_BITWIDTH:0] x_cnt;
    logic [SCREEN_Y_BITWIDTH:0] y_cnt;
    logic                    lv_prev;
    logic                    first_px;
    logic                    qualify, in_range, accept, overflow;
    logic                    frame_end, frame_entry, line_end;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= SYNC;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            SYNC:    if (!frame_valid) state_n = WAIT_FV;
            WAIT_FV: if (frame_valid)  state_n = ACTIVE;
            ACTIVE:  if (!frame_valid) state_n = WAIT_FV;
            default: state_n = SYNC;
        endcase
    end

    always_comb begin
        qualify     = (state == ACTIVE) && frame_valid && line_valid && pixel_valid;
        in_range    = (x_cnt < X_LIMIT) && (y_cnt < Y_LIMIT);
        accept      = qualify && in_range;
        overflow    = qualify && !in_range;
        frame_end   = (state == ACTIVE) && !frame_valid;
        frame_entry = (state == WAIT_FV) && frame_valid;
        // Frame end takes priority over a coincident line_valid fall.
        line_end    = (state == ACTIVE) && frame_valid && lv_prev && !line_valid;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_cnt           <= '0;
            y_cnt           <= '0;
            lv_prev         <= 1'b0;
            first_px        <= 1'b0;
            frame_err       <= 1'b0;
            frame_done      <= 1'b0;
            frame_start     <= 1'b0;
            pixel_out_valid <= 1'b0;
            pixel_in        <= '0;
            screen_x        <= '1;
            screen_y        <= '1;
        end else begin
            lv_prev         <= line_valid;
            frame_done      <= frame_end;
            frame_start     <= accept && first_px;
            pixel_out_valid <= accept;

            if (accept) begin
                pixel_in <= pixel_data;
                screen_x <= x_cnt;
                screen_y <= y_cnt;
            end else begin
                screen_x <= '1;
                screen_y <= '1;
            end

            if (frame_entry || frame_end) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (accept) begin
                x_cnt <= x_cnt + 1'b1;
            end else if (line_end) begin
                x_cnt <= '0;
                if (y_cnt < Y_LIMIT) y_cnt <= y_cnt + 1'b1;
            end

            if (frame_entry)  first_px <= 1'b1;
            else if (accept)  first_px <= 1'b0;

            if (frame_entry)   frame_err <= 1'b0;
            else if (overflow) frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_camera_coord_gen.sv
// Randomized scoreboard bench for camera_coord_gen with a frame/line level reference model.
module tb_camera_coord_gen;

    localparam int W = 4;
    localparam int H = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       frame_valid = 1'b0, line_valid = 1'b0, pixel_valid = 1'b0;
    logic [7:0] pixel_data = 8'h00;
    logic [3:0] screen_x, screen_y;
    logic [7:0] pixel_in;
    logic       pixel_out_valid, frame_start, frame_done, frame_err;

    camera_coord_gen #(
        .SCREEN_X_BITWIDTH(3), .SCREEN_Y_BITWIDTH(3), .CAMERA_PIXEL_BITWIDTH(7),
        .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)
    ) dut (
        .clock(clock), .reset(reset),
        .frame_valid(frame_valid), .line_valid(line_valid), .pixel_valid(pixel_valid),
        .pixel_data(pixel_data),
        .screen_x(screen_x), .screen_y(screen_y), .pixel_in(pixel_in),
        .pixel_out_valid(pixel_out_valid), .frame_start(frame_start),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] pix;
        int         x;
        int         y;
        bit         start;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0, n_fail = 0;
    int   dval = 0;

    // Reference model state: frame lock, position within frame, expected flags.
    bit   armed = 0, in_frame = 0, first = 0, lv_seen = 0;
    int   mx = 0, my = 0;
    int   exp_err = 0, exp_done = 0;
    logic [7:0] last_pix = 8'h00;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model(bit fv, bit lv, bit pv, logic [7:0] d);
        exp_t e;
        exp_done = 0;
        if (!in_frame) begin
            if (fv && armed) begin
                in_frame = 1; mx = 0; my = 0; first = 1; exp_err = 0;
            end else if (!fv) begin
                armed = 1;
            end
        end else if (!fv) begin
            in_frame = 0; armed = 1; exp_done = 1;
        end else if (lv && pv) begin
            if (mx < W && my < H) begin
                e.pix = d; e.x = mx; e.y = my; e.start = first;
                sbq.push_back(e);
                first = 0;
                mx++;
            end else begin
                exp_err = 1;
            end
        end else if (!lv && lv_seen) begin
            mx = 0;
            if (my < H) my++;
        end
        lv_seen = lv;
    endfunction

    task automatic step(input bit fv, input bit lv, input bit pv, input logic [7:0] d);
        frame_valid = fv; line_valid = lv; pixel_valid = pv; pixel_data = d;
        @(posedge clock); #1;
        model(fv, lv, pv, d);
    endtask

    function automatic logic [7:0] next_data(bit seq);
        logic [7:0] d;
        if (seq) begin d = 8'(dval); dval++; end
        else     d = 8'($urandom);
        return d;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'($urandom_range(0, 1)), 8'($urandom));
    endtask

    task automatic frame(input int nlines, input int npix, input int spacing,
                         input bit together, input bit seq);
        step(1, 0, 0, 8'($urandom));
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < npix; p++) begin
                step(1, 1, 1, next_data(seq));
                for (int s = 1; s < spacing; s++) step(1, 1, 0, 8'($urandom));
            end
            if (!(together && l == nlines - 1))
                for (int g = 0; g < 2; g++) step(1, 0, 1'($urandom_range(0, 1)), 8'($urandom));
        end
        step(0, 0, 0, 8'($urandom));
    endtask

    task automatic reset_pulse();
        reset = 0;
        in_frame = 0; armed = 0; lv_seen = 0; exp_err = 0; exp_done = 0;
        sbq.delete();
        #6;
        reset = 1;
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset) last_pix = 8'h00;
        if (pixel_out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pixel", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("pixel", int'(pixel_in), int'(e.pix));
                chk("screen_x", int'(screen_x), e.x);
                chk("screen_y", int'(screen_y), e.y);
                chk("frame_start", int'(frame_start === 1'b1), int'(e.start));
                last_pix = e.pix;
            end
        end else begin
            chk("idle_valid", int'(pixel_out_valid === 1'b0), 1);
            chk("idle_x", int'(screen_x), 15);
            chk("idle_y", int'(screen_y), 15);
            chk("idle_hold_pixel", int'(pixel_in), int'(last_pix));
            chk("idle_frame_start", int'(frame_start === 1'b1), 0);
        end
        chk("frame_done", int'(frame_done === 1'b1), exp_done);
        chk("frame_err", int'(frame_err === 1'b1), exp_err);
    end

    initial begin
        reset = 1;
        #1 reset = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1;

        // Basic 3x4 frame with sequential data, then idle.
        idle(3);
        dval = 0;
        frame(3, 4, 1, 0, 1);
        idle(3);

        // Reset after the fifth pixel while frame_valid stays high.
        dval = 100;
        step(1, 0, 0, 8'h00);
        for (int p = 0; p < 4; p++) step(1, 1, 1, next_data(1));
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        step(1, 1, 1, next_data(1));
        reset_pulse();
        for (int p = 0; p < 3; p++) step(1, 1, 1, next_data(1));
        step(1, 0, 0, 8'h00);
        for (int p = 0; p < 2; p++) step(1, 1, 1, next_data(1));
        step(0, 0, 0, 8'h00);
        frame(2, 4, 1, 0, 1);
        idle(2);

        // Overlong line: strobes 5 and 6 dropped, sticky error until next frame.
        dval = 40;
        step(1, 0, 0, 8'h00);
        for (int p = 0; p < 6; p++) step(1, 1, 1, next_data(1));
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        for (int p = 0; p < 2; p++) step(1, 1, 1, next_data(1));
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        idle(2);
        frame(1, 3, 1, 0, 1);
        idle(2);

        // Sparse strobes, one in three cycles.
        dval = 0;
        frame(3, 4, 3, 0, 1);

        // line_valid and frame_valid fall together, one-cycle gap, new frame.
        frame(3, 4, 1, 1, 1);
        frame(3, 4, 1, 0, 1);
        idle(2);

        // Randomized frames including extra lines (y saturation) and long lines.
        for (int f = 0; f < 12; f++) begin
            frame($urandom_range(1, 4), $urandom_range(1, 6), $urandom_range(1, 3),
                  1'($urandom_range(0, 1)), 0);
            idle($urandom_range(0, 2));
        end

        idle(3);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
